// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction sequencing FSM with a hardware return stack.
//
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB according to its
// decoded class. It raises the instruction-register load strobe in FETCH. It
// raises the PC update enable, with the matching source select, in the last
// cycle of the instruction. CALL pushes pc+1 and RET pops on that same edge.
//
// Ports:
//   clock        in   single clock, all state changes on posedge
//   reset        in   synchronous active-low reset
//   pc           in   [31:0] current PC value
//   op_class     in   [2:0] decoded class (sampled at the end of DECODE)
//   branch_taken in   branch condition, used only in EXEC of a BRANCH
//   stall        in   freezes the sequencer for the cycle
//   ir_en        out  instruction-register load strobe
//   pc_en        out  PC update enable
//   pc_src       out  [1:0] 0 PC+1, 1 jump target, 2 PC+sext(imm16), 3 stack top
//   top_stack    out  [31:0] current return-stack top (0 when empty)
//   state        out  [2:0] 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT
//   stack_count  out  [CNT_W-1:0] occupied stack entries
//   stack_err    out  stack overflow/underflow indication
//
// Build option: define STACK_TRAP_EN to make a stack error suppress the PC
// update, enter HALT and keep stack_err set until reset. When the macro is not
// defined, the PC still updates on an error and stack_err pulses for one cycle.
module pc_sequencer #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic [2:0]        op_class,
  input  logic              branch_taken,
  input  logic              stall,
  output logic              ir_en,
  output logic              pc_en,
  output logic [1:0]        pc_src,
  output logic [31:0]       top_stack,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  stack_count,
  output logic              stack_err
);

  localparam int unsigned IdxW = $clog2(STACK_DEPTH);

  localparam logic [2:0] OpLoad   = 3'd1;
  localparam logic [2:0] OpStore  = 3'd2;
  localparam logic [2:0] OpJmp    = 3'd3;
  localparam logic [2:0] OpCall   = 3'd4;
  localparam logic [2:0] OpRet    = 3'd5;
  localparam logic [2:0] OpBranch = 3'd6;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [31:0]       entries_q [STACK_DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic              err_q, err_d;

  logic              active;
  logic [2:0]        cur_op;
  logic              is_final;
  logic              full, empty;
  logic              err_evt;
  logic              take;
  logic              do_push, do_pop;
  logic [IdxW-1:0]   push_idx, top_idx;

  // The sequencer only advances when out of reset and not stalled.
  assign active = reset && !stall;

  // In DECODE the class comes straight from the decoder; later states use the
  // copy captured at the end of DECODE.
  assign cur_op = (state_q == StDecode) ? op_class : op_q;

  always_comb begin
    is_final = 1'b0;
    unique case (state_q)
      StDecode: is_final = (cur_op == OpJmp) || (cur_op == OpCall) || (cur_op == OpRet);
      StExec:   is_final = (cur_op == OpBranch);
      StMem:    is_final = (cur_op == OpStore);
      StWb:     is_final = 1'b1;
      default:  is_final = 1'b0;
    endcase
  end

  assign full  = (count_q == CNT_W'(STACK_DEPTH));
  assign empty = (count_q == '0);

  assign err_evt = active && is_final &&
                   (((cur_op == OpCall) && full) || ((cur_op == OpRet) && empty));

`ifdef STACK_TRAP_EN
  assign take  = active && is_final && !err_evt;
  assign err_d = err_q | err_evt;
`else
  assign take  = active && is_final;
  assign err_d = err_evt;
`endif

  // A CALL at full skips the push and a RET at empty leaves the count at 0.
  // With the trap build, take is already low on an error.
  assign do_push = take && (cur_op == OpCall) && !full;
  assign do_pop  = take && (cur_op == OpRet) && !empty;

  assign push_idx = IdxW'(count_q);
  assign top_idx  = IdxW'(count_q - CNT_W'(1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (active) begin
      unique case (state_q)
        StFetch:  state_d = StDecode;
        StDecode: state_d = is_final ? StFetch : StExec;
        StExec: begin
          if (cur_op == OpBranch) begin
            state_d = StFetch;
          end else if ((cur_op == OpLoad) || (cur_op == OpStore)) begin
            state_d = StMem;
          end else begin
            state_d = StWb;
          end
        end
        StMem:    state_d = (cur_op == OpLoad) ? StWb : StFetch;
        StWb:     state_d = StFetch;
        StHalt:   state_d = StHalt;
        default:  state_d = StFetch;
      endcase
`ifdef STACK_TRAP_EN
      if (err_evt) begin
        state_d = StHalt;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_en  = active && (state_q == StFetch);
    pc_en  = take;
    pc_src = 2'd0;
    if (take) begin
      unique case (cur_op)
        OpJmp, OpCall: pc_src = 2'd1;
        OpRet:         pc_src = 2'd3;
        OpBranch:      pc_src = branch_taken ? 2'd2 : 2'd0;
        default:       pc_src = 2'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decode capture, return stack and error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q    <= 3'd0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        entries_q[i] <= 32'd0;
      end
    end else begin
      if (active && (state_q == StDecode)) begin
        op_q <= op_class;
      end
      if (do_push) begin
        entries_q[push_idx] <= pc + 32'd1;
        count_q             <= count_q + CNT_W'(1);
      end else if (do_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
      err_q <= err_d;
    end
  end

  // The top is read combinationally, so a RET loads the old top on the same
  // edge that pops it.
  assign top_stack   = empty ? 32'd0 : entries_q[top_idx];
  assign state       = state_q;
  assign stack_count = count_q;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int DEPTH = 8;
`ifdef STACK_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [2:0]  op_class = 3'd0;
  logic        branch_taken = 1'b0;
  logic        stall = 1'b0;
  logic        ir_en, pc_en;
  logic [1:0]  pc_src;
  logic [31:0] top_stack;
  logic [2:0]  state;
  logic [3:0]  stack_count;
  logic        stack_err;

  pc_sequencer #(.STACK_DEPTH(DEPTH), .CNT_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .pc           (pc),
    .op_class     (op_class),
    .branch_taken (branch_taken),
    .stall        (stall),
    .ir_en        (ir_en),
    .pc_en        (pc_en),
    .pc_src       (pc_src),
    .top_stack    (top_stack),
    .state        (state),
    .stack_count  (stack_count),
    .stack_err    (stack_err)
  );

  always #5 clock = ~clock;

  // Reference model: the return stack as a queue, plus halt and error flags.
  logic [31:0] stk[$];
  bit          halted;
  bit          exp_err;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asserts reset for one cycle, then checks the post-reset state while
  // stalled so that the model does not move.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    stall = 1'($urandom);
    op_class = 3'($urandom);
    pc = $urandom;
    #1;
    chk("rst_ir_en", 32'(ir_en), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    @(posedge clock);
    stk.delete();
    halted  = 1'b0;
    exp_err = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    stall = 1'b1;
    #1;
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_count", 32'(stack_count), 32'd0);
    chk("post_rst_err", 32'(stack_err), 32'd0);
    chk("post_rst_top", top_stack, 32'd0);
    chk("post_rst_ir_en", 32'(ir_en), 32'd0);
    @(posedge clock);
  endtask

  task automatic halt_cycles(input int n);
    if (!halted) return;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset = 1'b1;
      stall = 1'($urandom);
      pc = $urandom;
      op_class = 3'($urandom);
      branch_taken = 1'($urandom);
      #1;
      chk("halt_state", 32'(state), 32'd5);
      chk("halt_ir_en", 32'(ir_en), 32'd0);
      chk("halt_pc_en", 32'(pc_en), 32'd0);
      chk("halt_pc_src", 32'(pc_src), 32'd0);
      chk("halt_count", 32'(stack_count), 32'(stk.size()));
      chk("halt_err", 32'(stack_err), 32'(exp_err));
      @(posedge clock);
    end
  endtask

  // Runs one instruction through its state trace with random stalls.
  // abort_at >= 0 applies reset in the cycle at that trace position.
  task automatic run_instr(input int op, input bit taken, input int abort_at);
    int          seq[$];
    int          pos;
    int          nst;
    bit          stl, fin, full, empty, evt, e_pcen;
    logic [1:0]  e_src;
    logic [31:0] pcv, e_top;
    case (op)
      1:       seq = '{0, 1, 2, 3, 4};
      2:       seq = '{0, 1, 2, 3};
      3, 4, 5: seq = '{0, 1};
      6:       seq = '{0, 1, 2};
      default: seq = '{0, 1, 2, 4};
    endcase
    pos = 0;
    nst = 0;
    while (pos < seq.size() && !halted) begin
      if (pos == abort_at) begin
        do_reset();
        return;
      end
      stl = (nst < 8) && ($urandom_range(0, 3) == 0);
      if (stl) nst++;
      fin = (pos == seq.size() - 1);
      pcv = $urandom;
      @(negedge clock);
      reset = 1'b1;
      stall = stl;
      pc = pcv;
      op_class = (seq[pos] == 1) ? 3'(op) : 3'($urandom);
      branch_taken = (seq[pos] == 2) ? taken : 1'($urandom);
      #1;
      full   = (stk.size() == DEPTH);
      empty  = (stk.size() == 0);
      evt    = 1'b0;
      e_pcen = 1'b0;
      e_src  = 2'd0;
      if (!stl && fin) begin
        evt    = ((op == 4) && full) || ((op == 5) && empty);
        e_pcen = TRAP ? !evt : 1'b1;
        if (e_pcen) begin
          case (op)
            3, 4:    e_src = 2'd1;
            5:       e_src = 2'd3;
            6:       e_src = taken ? 2'd2 : 2'd0;
            default: e_src = 2'd0;
          endcase
        end
      end
      e_top = empty ? 32'd0 : stk[$];
      chk("state", 32'(state), 32'(seq[pos]));
      chk("ir_en", 32'(ir_en), 32'(!stl && (seq[pos] == 0)));
      chk("pc_en", 32'(pc_en), 32'(e_pcen));
      chk("pc_src", 32'(pc_src), 32'(e_src));
      chk("top_stack", top_stack, e_top);
      chk("stack_count", 32'(stack_count), 32'(stk.size()));
      chk("stack_err", 32'(stack_err), 32'(exp_err));
      @(posedge clock);
      if (!stl) begin
        if (fin) begin
          if (TRAP && evt) begin
            halted = 1'b1;
          end else begin
            if ((op == 4) && !full) stk.push_back(pcv + 32'd1);
            if ((op == 5) && !empty) void'(stk.pop_back());
          end
        end
        pos++;
      end
      exp_err = TRAP ? (exp_err | evt) : evt;
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    halted  = 1'b0;
    exp_err = 1'b0;
    repeat (2) @(posedge clock);
    do_reset();

    // Basic classes, including class 7 treated as ALU.
    run_instr(0, 1'b0, -1);
    run_instr(1, 1'b0, -1);
    run_instr(2, 1'b0, -1);
    run_instr(7, 1'b0, -1);
    run_instr(3, 1'b0, -1);

    // CALL then RET, branches taken and not taken.
    run_instr(4, 1'b0, -1);
    run_instr(5, 1'b0, -1);
    run_instr(6, 1'b1, -1);
    run_instr(6, 1'b0, -1);

    // Nine CALLs overflow an eight-entry stack.
    for (int i = 0; i < 9; i++) run_instr(4, 1'b0, -1);
    halt_cycles(3);
    run_instr(0, 1'b0, -1);
    do_reset();

    // RET on empty, then reset during EXEC of the next ALU.
    run_instr(5, 1'b0, -1);
    halt_cycles(3);
    if (halted) do_reset();
    else run_instr(0, 1'b0, 2);

    // Random instruction mix with occasional mid-instruction resets.
    for (int i = 0; i < 120; i++) begin
      int op;
      int ab;
      op = ($urandom_range(0, 3) == 0) ? 4 : int'($urandom_range(0, 7));
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 2)) : -1;
      run_instr(op, 1'($urandom), ab);
      if (halted) begin
        halt_cycles(2);
        do_reset();
      end
    end
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 8, return-stack entries (power of two, 2..64).
REQ-002 Parameter CNT_W, default 4, width of stack_count (log2(STACK_DEPTH)+1).
REQ-003 clock  input  1  single clock; all state changes on posedge clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 pc  input  32  current PC value from the PC register.
REQ-006 op_class  input  3  decoded class: 0 ALU, 1 LOAD, 2 STORE, 3 JMP, 4 CALL, 5 RET, 6 BRANCH, 7 treated as ALU.
REQ-007 branch_taken  input  1  branch condition result; sampled only in EXEC of a BRANCH.
REQ-008 stall  input  1  freezes the sequencer for the cycle.
REQ-009 ir_en  output  1  instruction-register load strobe.
REQ-010 pc_en  output  1  PC update enable.
REQ-011 pc_src  output  2  PC source select: 0 PC+1, 1 {PC[31:26],Imm26}, 2 PC+sext(Imm16), 3 stack top.
REQ-012 top_stack  output  32  current return-stack top.
REQ-013 state  output  3  FSM state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT.
REQ-014 stack_count  output  CNT_W  occupied stack entries.
REQ-015 stack_err  output  1  stack overflow/underflow indication.

Function
REQ-016 Sequences SHALL be: ALU F-D-E-WB; LOAD F-D-E-MEM-WB; STORE F-D-E-MEM; JMP/CALL/RET F-D; BRANCH F-D-E; after the final state the FSM SHALL return to FETCH.
REQ-017 ir_en SHALL be 1 exactly in FETCH cycles with stall=0.
REQ-018 pc_en SHALL be 1 only in the final state cycle of an instruction with stall=0, so the PC updates once per instruction at the end of that cycle.
REQ-019 pc_src SHALL be 0 except in a pc_en cycle: JMP and CALL give 1, RET gives 3, BRANCH gives 2 if branch_taken else 0.
REQ-020 op_class SHALL be sampled at the end of DECODE; it is don't-care in all other states.
REQ-021 CALL SHALL push pc+1 (32-bit wrap) on the pc_en clock edge; RET SHALL pop on the pc_en clock edge.
REQ-022 top_stack SHALL be combinational: entry[stack_count-1], or 0 when empty, so the pop edge and the PC load of the old top coincide.
REQ-023 While stall=1: state, stack and count SHALL hold; ir_en and pc_en SHALL be 0; pc_src SHALL be 0.
REQ-024 Overflow (CALL with stack_count=STACK_DEPTH) and underflow (RET with stack_count=0) SHALL be errors handled per REQ-029/030; the count SHALL never exceed STACK_DEPTH or go below 0.
REQ-025 In HALT: ir_en=0, pc_en=0, pc_src=0; exit only by reset.

Reset
REQ-026 With reset=0 at a posedge: state=FETCH, stack_count=0, all entries=0, stack_err=0.
REQ-027 During reset, ir_en, pc_en and pc_src SHALL be 0 combinationally.
REQ-028 Reset mid-instruction SHALL abandon that instruction with no push/pop; sequencing restarts at FETCH in the first cycle after reset=1.

Configuration
REQ-029 With STACK_TRAP_EN defined: on error, pc_en SHALL be 0 for that cycle, no push/pop occurs, the FSM enters HALT, and stack_err stays 1 (sticky) until reset.
REQ-030 Without STACK_TRAP_EN: on error, the PC still updates per REQ-019; a CALL at full skips the push; a RET at empty loads 0; stack_err pulses 1 for one cycle, registered (high the cycle after the error edge).

Verification
REQ-031 Reset, then ALU, LOAD, STORE with stall=0 -> pc_en pulses at cycles 4, 9 and 13 with pc_src=0; state trace 0,1,2,4 / 0,1,2,3,4 / 0,1,2,3.
REQ-032 CALL at pc=0x100, then RET -> stack_count 1, top_stack 0x101; on the RET pc_en cycle, pc_src=3 and top_stack=0x101; stack_count 0 afterwards.
REQ-033 BRANCH with branch_taken=1, then BRANCH with branch_taken=0 -> pc_src=2, then 0; each pc_en occurs in EXEC.
REQ-034 stall=1 for 3 cycles in DECODE of a CALL -> state holds 1, pc_en=0, no push; the CALL then completes normally.
REQ-035 9 CALLs with STACK_DEPTH=8 -> with macro: HALT, stack_err sticky, stack_count 8, no pc_en until reset; without macro: 9th jumps with pc_src=1, count stays 8, single stack_err pulse.
REQ-036 RET on empty stack, then reset asserted during EXEC of the next ALU -> macro-dependent error per REQ-029/030; after reset: state 0, count 0, stack_err 0.
